// File: rtl/riscv_wb_commit_unit_pkg.sv
// Shared encodings for the writeback/commit stage: PC-select targets, xRET codes and redirect FSM states.
package riscv_pkg;

  localparam logic [1:0] PCSEL_SEQ  = 2'b00;
  localparam logic [1:0] PCSEL_TRAP = 2'b01;
  localparam logic [1:0] PCSEL_MEPC = 2'b10;
  localparam logic [1:0] PCSEL_SEPC = 2'b11;

  localparam logic [1:0] RET_NONE = 2'b00;
  localparam logic [1:0] RET_MRET = 2'b01;
  localparam logic [1:0] RET_SRET = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FLUSH = 2'd2
  } wb_state_e;

endpackage

// File: rtl/riscv_wb_commit_unit_if.sv
// Writeback bus: MEM-stage results and trap controls in, register-file write port and redirect controls out.
// Handshake: no ready path; i_riscv_wb_valid qualifies the instruction for exactly the cycle it is high.
interface riscv_wb_commit_unit_if #(
  parameter int XLEN      = 64,
  parameter int NUM_SRC   = 5,
  parameter int SRC_SEL_W = 3
);
  logic                    i_riscv_wb_valid;
  logic [SRC_SEL_W-1:0]    i_riscv_wb_resultsrc;
  logic [NUM_SRC*XLEN-1:0] i_riscv_wb_srcdata;
  logic [XLEN-1:0]         i_riscv_wb_csrout;
  logic                    i_riscv_wb_iscsr;
  logic [4:0]              i_riscv_wb_rdaddr;
  logic                    i_riscv_wb_regwrite;
  logic                    i_riscv_wb_gototrap;
  logic [1:0]              i_riscv_wb_returnfromtrap;
  logic                    i_riscv_wb_icache_stall;
  logic [XLEN-1:0]         o_riscv_wb_rddata;
  logic [4:0]              o_riscv_wb_rdaddr;
  logic                    o_riscv_wb_regwrite;
  logic [1:0]              o_riscv_wb_pcsel;
  logic                    o_riscv_wb_flush;
  logic                    o_riscv_wb_busy;

  modport master (
    output i_riscv_wb_valid, i_riscv_wb_resultsrc, i_riscv_wb_srcdata, i_riscv_wb_csrout,
           i_riscv_wb_iscsr, i_riscv_wb_rdaddr, i_riscv_wb_regwrite, i_riscv_wb_gototrap,
           i_riscv_wb_returnfromtrap, i_riscv_wb_icache_stall,
    input  o_riscv_wb_rddata, o_riscv_wb_rdaddr, o_riscv_wb_regwrite, o_riscv_wb_pcsel,
           o_riscv_wb_flush, o_riscv_wb_busy
  );

  modport slave (
    input  i_riscv_wb_valid, i_riscv_wb_resultsrc, i_riscv_wb_srcdata, i_riscv_wb_csrout,
           i_riscv_wb_iscsr, i_riscv_wb_rdaddr, i_riscv_wb_regwrite, i_riscv_wb_gototrap,
           i_riscv_wb_returnfromtrap, i_riscv_wb_icache_stall,
    output o_riscv_wb_rddata, o_riscv_wb_rdaddr, o_riscv_wb_regwrite, o_riscv_wb_pcsel,
           o_riscv_wb_flush, o_riscv_wb_busy
  );
endinterface

// File: rtl/riscv_wb_commit_unit_redirect_fsm.sv
// Trap/xRET redirect FSM: latches the redirect target, waits out I-cache stalls, then flushes for FLUSH_CYCLES.
module riscv_wb_redirect_fsm
  import riscv_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic       gototrap,
  input  logic [1:0] returnfromtrap,
  input  logic       icache_stall,
  output logic [1:0] pcsel,
  output logic       flush,
  output logic       busy,
  output wb_state_e  state
);
  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);
  // The accepting cycle is itself the first flush cycle, so a 1-cycle flush never enters FLUSH.
  localparam wb_state_e AFTER_GO = (FLUSH_CYCLES == 1) ? ST_IDLE : ST_FLUSH;

  wb_state_e  state_n;
  logic [1:0] target, pcsel_q, pcsel_q_n;
  logic [3:0] cnt, cnt_n;
  logic       request;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      pcsel_q <= PCSEL_SEQ;
      cnt     <= 4'd0;
    end else begin
      state   <= state_n;
      pcsel_q <= pcsel_q_n;
      cnt     <= cnt_n;
    end
  end

  always_comb begin
    request = 1'b0;
    target  = PCSEL_SEQ;
    if (valid) begin
      if (gototrap) begin
        request = 1'b1;
        target  = PCSEL_TRAP;
      end else if (returnfromtrap == RET_MRET) begin
        request = 1'b1;
        target  = PCSEL_MEPC;
      end else if (returnfromtrap == RET_SRET) begin
        request = 1'b1;
        target  = PCSEL_SEPC;
      end
    end
  end

  always_comb begin
    state_n   = state;
    pcsel_q_n = pcsel_q;
    cnt_n     = cnt;
    pcsel     = PCSEL_SEQ;
    flush     = 1'b0;
    busy      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (request) begin
          busy      = 1'b1;
          pcsel_q_n = target;
          if (icache_stall) begin
            state_n = ST_PEND;
          end else begin
            flush   = 1'b1;
            pcsel   = target;
            cnt_n   = CNT_LOAD;
            state_n = AFTER_GO;
          end
        end
      end
      ST_PEND: begin
        busy = 1'b1;
        if (!icache_stall) begin
          flush   = 1'b1;
          pcsel   = pcsel_q;
          cnt_n   = CNT_LOAD;
          state_n = AFTER_GO;
        end
      end
      ST_FLUSH: begin
        busy  = 1'b1;
        flush = 1'b1;
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end
endmodule

// File: rtl/riscv_wb_commit_unit.sv
// Writeback/commit stage: rd data select, registered register-file write port, trap redirect control.
// Optional RISCV_WB_INSTRET_EN adds a 64-bit committed-instruction counter output.
module riscv_wb_commit_unit
  import riscv_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int NUM_SRC      = 5,
  parameter int SRC_SEL_W    = 3,
  parameter int FLUSH_CYCLES = 1
) (
  input logic i_riscv_wb_clk,
  input logic i_riscv_wb_rst,
  riscv_wb_commit_unit_if.slave wb
`ifdef RISCV_WB_INSTRET_EN
  ,
  output logic [63:0] o_riscv_wb_instret
`endif
);
  wb_state_e       fsm_state;
  logic [XLEN-1:0] rd_next;
  logic            squash;

  riscv_wb_redirect_fsm #(.FLUSH_CYCLES(FLUSH_CYCLES)) u_fsm (
    .clk            (i_riscv_wb_clk),
    .rst            (i_riscv_wb_rst),
    .valid          (wb.i_riscv_wb_valid),
    .gototrap       (wb.i_riscv_wb_gototrap),
    .returnfromtrap (wb.i_riscv_wb_returnfromtrap),
    .icache_stall   (wb.i_riscv_wb_icache_stall),
    .pcsel          (wb.o_riscv_wb_pcsel),
    .flush          (wb.o_riscv_wb_flush),
    .busy           (wb.o_riscv_wb_busy),
    .state          (fsm_state)
  );

  // Out-of-range selects fall through to zero since no loop iteration matches.
  always_comb begin
    rd_next = '0;
    if (wb.i_riscv_wb_iscsr) begin
      rd_next = wb.i_riscv_wb_csrout;
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (wb.i_riscv_wb_resultsrc == SRC_SEL_W'(k)) rd_next = wb.i_riscv_wb_srcdata[k*XLEN +: XLEN];
      end
    end
  end

  assign squash = wb.i_riscv_wb_gototrap | (wb.i_riscv_wb_returnfromtrap != RET_NONE) |
                  (fsm_state != ST_IDLE);

  always_ff @(posedge i_riscv_wb_clk) begin
    if (i_riscv_wb_rst) begin
      wb.o_riscv_wb_rddata   <= '0;
      wb.o_riscv_wb_rdaddr   <= '0;
      wb.o_riscv_wb_regwrite <= 1'b0;
    end else begin
      wb.o_riscv_wb_rddata   <= rd_next;
      wb.o_riscv_wb_rdaddr   <= wb.i_riscv_wb_rdaddr;
      wb.o_riscv_wb_regwrite <= wb.i_riscv_wb_valid & wb.i_riscv_wb_regwrite & ~squash;
    end
  end

`ifdef RISCV_WB_INSTRET_EN
  logic [63:0] instret_q;
  // xRET retires even though its rd write is squashed; a trapped instruction does not.
  always_ff @(posedge i_riscv_wb_clk) begin
    if (i_riscv_wb_rst) instret_q <= '0;
    else if (wb.i_riscv_wb_valid & ~wb.i_riscv_wb_gototrap & (fsm_state == ST_IDLE))
      instret_q <= instret_q + 64'd1;
  end
  assign o_riscv_wb_instret = instret_q;
`endif
endmodule

// File: tb/tb_riscv_wb_commit_unit.sv
// Bench for riscv_wb_commit_unit: data-path vector table, redirect corner sequences, randomized model run.
module tb_riscv_wb_commit_unit;
  import riscv_pkg::*;

  localparam int XLEN = 64, NUM_SRC = 5, SRC_SEL_W = 3, FC = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  riscv_wb_commit_unit_if #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .SRC_SEL_W(SRC_SEL_W)) wb();
`ifdef RISCV_WB_INSTRET_EN
  logic [63:0] instret;
`endif

  riscv_wb_commit_unit #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .SRC_SEL_W(SRC_SEL_W), .FLUSH_CYCLES(FC)) dut (
    .i_riscv_wb_clk (clk),
    .i_riscv_wb_rst (rst),
    .wb             (wb)
`ifdef RISCV_WB_INSTRET_EN
    ,
    .o_riscv_wb_instret (instret)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sel;
    logic        iscsr;
    logic [63:0] csr;
    logic [4:0]  rd;
    logic        rw;
    logic [63:0] exp_data;
    logic        exp_rw;
  } vec_t;

  vec_t        vecs[10];
  logic [63:0] src_m[NUM_SRC];
  logic [69:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic set_srcs();
    for (int k = 0; k < NUM_SRC; k++) wb.i_riscv_wb_srcdata[k*XLEN +: XLEN] = src_m[k];
  endtask

  task automatic quiet();
    wb.i_riscv_wb_valid          = 1'b0;
    wb.i_riscv_wb_resultsrc      = '0;
    wb.i_riscv_wb_csrout         = '0;
    wb.i_riscv_wb_iscsr          = 1'b0;
    wb.i_riscv_wb_rdaddr         = '0;
    wb.i_riscv_wb_regwrite       = 1'b0;
    wb.i_riscv_wb_gototrap       = 1'b0;
    wb.i_riscv_wb_returnfromtrap = RET_NONE;
    wb.i_riscv_wb_icache_stall   = 1'b0;
    set_srcs();
  endtask

  // Called at a falling edge with inputs already applied; checks comb outputs, then the registered write enable.
  task automatic hcyc(input string name, input logic [1:0] ep, input logic ef, input logic eb, input logic er);
    #1;
    chk({name, ".pcsel"}, 64'(wb.o_riscv_wb_pcsel), 64'(ep));
    chk({name, ".flush"}, 64'(wb.o_riscv_wb_flush), 64'(ef));
    chk({name, ".busy"},  64'(wb.o_riscv_wb_busy),  64'(eb));
    @(posedge clk); #1;
    chk({name, ".regwrite"}, 64'(wb.o_riscv_wb_regwrite), 64'(er));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    quiet();
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference model of the redirect behaviour: a pending target and a count of remaining flush cycles.
  int          m_pend, m_flush_left;
  logic [63:0] m_instret;

  task automatic rand_cycle(input int idx);
    logic [1:0]  e_pcsel;
    logic        e_flush, e_busy, idle, squash, e_rw;
    logic [63:0] e_data;
    logic [69:0] got, exp;
    int          tgt, t;
    wb.i_riscv_wb_valid          = ($urandom_range(0, 3) != 0);
    wb.i_riscv_wb_gototrap       = ($urandom_range(0, 7) == 0);
    wb.i_riscv_wb_returnfromtrap = ($urandom_range(0, 7) < 2) ? 2'($urandom_range(0, 3)) : RET_NONE;
    wb.i_riscv_wb_icache_stall   = ($urandom_range(0, 2) == 0);
    wb.i_riscv_wb_resultsrc      = 3'($urandom_range(0, 7));
    wb.i_riscv_wb_iscsr          = ($urandom_range(0, 7) == 0);
    wb.i_riscv_wb_csrout         = {$urandom(), $urandom()};
    wb.i_riscv_wb_rdaddr         = 5'($urandom_range(0, 31));
    wb.i_riscv_wb_regwrite       = 1'($urandom_range(0, 1));
    for (int k = 0; k < NUM_SRC; k++) src_m[k] = {$urandom(), $urandom()};
    set_srcs();

    idle = (m_pend == 0) && (m_flush_left == 0);
    tgt = 0;
    if (wb.i_riscv_wb_valid) begin
      if (wb.i_riscv_wb_gototrap) tgt = 1;
      else if (wb.i_riscv_wb_returnfromtrap == 2'b01) tgt = 2;
      else if (wb.i_riscv_wb_returnfromtrap == 2'b10) tgt = 3;
    end
    e_pcsel = 2'b00; e_flush = 1'b0; e_busy = 1'b0;
    if (m_flush_left > 0) begin
      e_flush = 1'b1; e_busy = 1'b1;
      m_flush_left--;
    end else begin
      t = (m_pend != 0) ? m_pend : tgt;
      if (t != 0) begin
        e_busy = 1'b1;
        if (wb.i_riscv_wb_icache_stall) begin
          m_pend = t;
        end else begin
          e_flush = 1'b1; e_pcsel = 2'(t);
          m_flush_left = FC - 1;
          m_pend = 0;
        end
      end
    end
    squash = wb.i_riscv_wb_gototrap || (wb.i_riscv_wb_returnfromtrap != 2'b00) || !idle;
    e_rw = wb.i_riscv_wb_valid && wb.i_riscv_wb_regwrite && !squash;
    if (wb.i_riscv_wb_iscsr) e_data = wb.i_riscv_wb_csrout;
    else if (wb.i_riscv_wb_resultsrc < NUM_SRC) e_data = src_m[wb.i_riscv_wb_resultsrc];
    else e_data = 64'd0;
    if (wb.i_riscv_wb_valid && idle && !wb.i_riscv_wb_gototrap) m_instret++;
    exp_q.push_back({e_data, wb.i_riscv_wb_rdaddr, e_rw});

    #1;
    chk($sformatf("rnd%0d.pcsel", idx), 64'(wb.o_riscv_wb_pcsel), 64'(e_pcsel));
    chk($sformatf("rnd%0d.flush", idx), 64'(wb.o_riscv_wb_flush), 64'(e_flush));
    chk($sformatf("rnd%0d.busy", idx),  64'(wb.o_riscv_wb_busy),  64'(e_busy));
    @(posedge clk); #1;
    exp = exp_q.pop_front();
    got = {wb.o_riscv_wb_rddata, wb.o_riscv_wb_rdaddr, wb.o_riscv_wb_regwrite};
    chk($sformatf("rnd%0d.rddata", idx),   got[69:6], exp[69:6]);
    chk($sformatf("rnd%0d.rdaddr", idx),   64'(got[5:1]), 64'(exp[5:1]));
    chk($sformatf("rnd%0d.regwrite", idx), 64'(got[0]), 64'(exp[0]));
    @(negedge clk);
  endtask

  initial begin
    src_m[0] = 64'h0000_0000_0000_1004;
    src_m[1] = 64'hFFFF_FFFF_FFFF_FFF0;
    src_m[2] = 64'h0000_0000_DEAD_BEEF;
    src_m[3] = 64'h0000_0000_ABCD_E000;
    src_m[4] = 64'h0000_0000_0000_0001;
    vecs[0] = '{3'd2, 1'b0, 64'h0,    5'd7,  1'b1, 64'hDEAD_BEEF,          1'b1};
    vecs[1] = '{3'd0, 1'b0, 64'h0,    5'd1,  1'b1, 64'h1004,               1'b1};
    vecs[2] = '{3'd1, 1'b0, 64'h0,    5'd31, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1};
    vecs[3] = '{3'd3, 1'b0, 64'h0,    5'd0,  1'b1, 64'hABCD_E000,          1'b1};
    vecs[4] = '{3'd4, 1'b0, 64'h0,    5'd5,  1'b0, 64'h1,                  1'b0};
    vecs[5] = '{3'd6, 1'b1, 64'h1800, 5'd9,  1'b1, 64'h1800,               1'b1};
    vecs[6] = '{3'd6, 1'b0, 64'h1800, 5'd9,  1'b1, 64'h0,                  1'b1};
    vecs[7] = '{3'd5, 1'b0, 64'h0,    5'd12, 1'b1, 64'h0,                  1'b1};
    vecs[8] = '{3'd7, 1'b0, 64'h0,    5'd13, 1'b1, 64'h0,                  1'b1};
    vecs[9] = '{3'd2, 1'b1, 64'hCAFE, 5'd3,  1'b1, 64'hCAFE,               1'b1};

    // Reset state, sampled while reset is still asserted with quiet inputs.
    rst = 1'b1;
    quiet();
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("reset.rddata",   wb.o_riscv_wb_rddata, 64'd0);
    chk("reset.rdaddr",   64'(wb.o_riscv_wb_rdaddr), 64'd0);
    chk("reset.regwrite", 64'(wb.o_riscv_wb_regwrite), 64'd0);
    chk("reset.pcsel",    64'(wb.o_riscv_wb_pcsel), 64'd0);
    chk("reset.flush",    64'(wb.o_riscv_wb_flush), 64'd0);
    chk("reset.busy",     64'(wb.o_riscv_wb_busy), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      quiet();
      wb.i_riscv_wb_valid     = 1'b1;
      wb.i_riscv_wb_resultsrc = vecs[i].sel;
      wb.i_riscv_wb_iscsr     = vecs[i].iscsr;
      wb.i_riscv_wb_csrout    = vecs[i].csr;
      wb.i_riscv_wb_rdaddr    = vecs[i].rd;
      wb.i_riscv_wb_regwrite  = vecs[i].rw;
      @(posedge clk); #1;
      chk($sformatf("vec%0d.rddata", i),   wb.o_riscv_wb_rddata, vecs[i].exp_data);
      chk($sformatf("vec%0d.rdaddr", i),   64'(wb.o_riscv_wb_rdaddr), 64'(vecs[i].rd));
      chk($sformatf("vec%0d.regwrite", i), 64'(wb.o_riscv_wb_regwrite), 64'(vecs[i].exp_rw));
      @(negedge clk);
    end

    // Trap without stall: redirect same cycle, three flush cycles, younger instructions squashed.
    quiet();
    wb.i_riscv_wb_valid = 1'b1; wb.i_riscv_wb_regwrite = 1'b1; wb.i_riscv_wb_rdaddr = 5'd3;
    wb.i_riscv_wb_gototrap = 1'b1;
    hcyc("trap0", 2'b01, 1'b1, 1'b1, 1'b0);
    wb.i_riscv_wb_gototrap = 1'b0;
    hcyc("trap1", 2'b00, 1'b1, 1'b1, 1'b0);
    hcyc("trap2", 2'b00, 1'b1, 1'b1, 1'b0);
    hcyc("trap3", 2'b00, 1'b0, 1'b0, 1'b1);

    // mret held across a 4-cycle I-cache stall; a trap during PEND is ignored.
    quiet();
    wb.i_riscv_wb_valid = 1'b1; wb.i_riscv_wb_regwrite = 1'b1;
    wb.i_riscv_wb_returnfromtrap = RET_MRET; wb.i_riscv_wb_icache_stall = 1'b1;
    hcyc("mret_pend0", 2'b00, 1'b0, 1'b1, 1'b0);
    quiet(); wb.i_riscv_wb_icache_stall = 1'b1;
    hcyc("mret_pend1", 2'b00, 1'b0, 1'b1, 1'b0);
    wb.i_riscv_wb_valid = 1'b1; wb.i_riscv_wb_gototrap = 1'b1; wb.i_riscv_wb_regwrite = 1'b1;
    hcyc("mret_pend2", 2'b00, 1'b0, 1'b1, 1'b0);
    quiet(); wb.i_riscv_wb_icache_stall = 1'b1;
    hcyc("mret_pend3", 2'b00, 1'b0, 1'b1, 1'b0);
    wb.i_riscv_wb_icache_stall = 1'b0;
    hcyc("mret_go",   2'b10, 1'b1, 1'b1, 1'b0);
    hcyc("mret_fl1",  2'b00, 1'b1, 1'b1, 1'b0);
    hcyc("mret_fl2",  2'b00, 1'b1, 1'b1, 1'b0);
    hcyc("mret_done", 2'b00, 1'b0, 1'b0, 1'b0);

    // Trap wins over mret; trap during FLUSH ignored; stall during FLUSH does not pause the count.
    quiet();
    wb.i_riscv_wb_valid = 1'b1; wb.i_riscv_wb_gototrap = 1'b1; wb.i_riscv_wb_returnfromtrap = RET_MRET;
    hcyc("prio", 2'b01, 1'b1, 1'b1, 1'b0);
    wb.i_riscv_wb_returnfromtrap = RET_NONE;
    hcyc("ign1", 2'b00, 1'b1, 1'b1, 1'b0);
    wb.i_riscv_wb_icache_stall = 1'b1;
    hcyc("ign2", 2'b00, 1'b1, 1'b1, 1'b0);
    quiet();
    hcyc("ign_done", 2'b00, 1'b0, 1'b0, 1'b0);

    // Reset while an sret is pending drops the redirect.
    quiet();
    wb.i_riscv_wb_valid = 1'b1; wb.i_riscv_wb_returnfromtrap = RET_SRET; wb.i_riscv_wb_icache_stall = 1'b1;
    hcyc("sret_pend", 2'b00, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    quiet(); wb.i_riscv_wb_icache_stall = 1'b1;
    @(posedge clk); #1;
    chk("rst_pend.rddata",   wb.o_riscv_wb_rddata, 64'd0);
    chk("rst_pend.regwrite", 64'(wb.o_riscv_wb_regwrite), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    wb.i_riscv_wb_icache_stall = 1'b0;
    hcyc("post_rst", 2'b00, 1'b0, 1'b0, 1'b0);

`ifdef RISCV_WB_INSTRET_EN
    do_reset();
    chk("instret.reset", instret, 64'd0);
    wb.i_riscv_wb_valid = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    quiet();
    @(negedge clk);
    chk("instret.ten", instret, 64'd10);
`endif

    // Randomized run against the reference model.
    do_reset();
    m_pend = 0; m_flush_left = 0; m_instret = 64'd0;
    exp_q.delete();
    for (int i = 0; i < 400; i++) rand_cycle(i);
`ifdef RISCV_WB_INSTRET_EN
    chk("rnd.instret", instret, m_instret);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
